sim_host: RTL
=============

SIM_HOST -- requirements
Module: sim_host

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, giving the console FIFO depth in bytes; it must be a power of two and at least 2.
REQ-002 The block SHALL have parameter OFS_W, default 5, giving the width of the register offset decoded from req_addr.
REQ-003 clk  in  1  single clock; all state SHALL be clocked on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 req_vld/req_rdy  in/out  1/1  request handshake; a request transfers when both are high.
REQ-006 req_addr  in  32  byte address; only bits [OFS_W-1:2] are decoded.
REQ-007 req_wr  in  1  1 = write, 0 = read.
REQ-008 req_wdata  in  32  write data.
REQ-009 req_wstrb  in  4  byte enables; a write with req_wstrb[0]=0 SHALL be ignored but still acknowledged.
REQ-010 rsp_vld/rsp_rdy  out/in  1/1  response handshake.
REQ-011 rsp_rdata  out  32  read data; SHALL be 0 for writes.
REQ-012 rsp_err  out  1  high for an unmapped offset.
REQ-013 con_vld/con_rdy  out/in  1/1  console byte stream toward the bench.
REQ-014 con_data  out  8  console byte.
REQ-015 finish  out  1  sticky program-done flag.
REQ-016 exit_code  out  31  program exit code.

Function
REQ-017 Register map (offsets): 0x00 CONSOLE, 0x04 STATUS, 0x08 TOHOST, 0x0C CYCLE_LO, 0x10 CYCLE_HI.
REQ-018 CONSOLE write SHALL push req_wdata[7:0] into the FIFO; CONSOLE read SHALL return the FIFO occupancy, zero-extended.
REQ-019 STATUS read SHALL return {29'b0, finish, fifo_empty, fifo_full}; writes to STATUS SHALL be ignored.
REQ-020 TOHOST write with req_wdata[0]=1 SHALL set finish and latch exit_code=req_wdata[31:1]; a later TOHOST write SHALL NOT change either output.
REQ-021 A TOHOST write with req_wdata[0]=0 SHALL be ignored; TOHOST read SHALL return {exit_code, finish}.
REQ-022 Control SHALL be a two-state FSM, IDLE and RSP.
REQ-023 In IDLE the request SHALL be accepted, and the FSM SHALL enter RSP on the next edge with rsp_vld=1; latency is exactly one cycle.
REQ-024 In RSP, req_rdy SHALL be 0, and the FSM SHALL return to IDLE on rsp_vld&&rsp_rdy; at most one request is outstanding.
REQ-025 In IDLE, req_rdy SHALL be 1, except it SHALL be 0 while a CONSOLE write with wstrb[0]=1 is presented and the FIFO is full; that is back-pressure, not an error.
REQ-026 rsp_rdata and rsp_err SHALL hold stable while rsp_vld=1 and rsp_rdy=0.
REQ-027 An unmapped offset SHALL still be accepted; it SHALL return rsp_err=1 and rsp_rdata=0, and SHALL have no side effect.
REQ-028 con_vld SHALL equal !fifo_empty, and con_data SHALL be the FIFO head; the head SHALL pop on con_vld&&con_rdy.
REQ-029 A push and a pop in the same cycle SHALL leave occupancy unchanged and SHALL be legal when the FIFO is full.
REQ-030 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide with a wrap bit; full and empty SHALL be derived from the wrap bit.
REQ-031 The cycle counter SHALL be 64 bits, increment every cycle after reset, and wrap silently from all-ones to 0.
REQ-032 A CYCLE_LO read SHALL snapshot the upper word; a CYCLE_HI read SHALL return that snapshot, so the read pair is coherent.

Reset
REQ-033 On rst_n low, the block SHALL asynchronously clear the FSM to IDLE and the FIFO to empty.
REQ-034 On rst_n low, the block SHALL also clear the pointers, finish, exit_code, the counter and the snapshot.
REQ-035 During reset the outputs SHALL be req_rdy=0 (held while rst_n=0), rsp_vld=0, rsp_rdata=0, rsp_err=0, con_vld=0, con_data=0, finish=0, exit_code=0.
REQ-036 Reset asserted mid-transaction SHALL drop the pending response and discard all FIFO contents.

Configuration
REQ-037 With macro SIM_HOST_CYCLE_CNT_EN defined, the block SHALL include the counter, the snapshot and offsets 0x0C/0x10.
REQ-038 Without SIM_HOST_CYCLE_CNT_EN, the counter and snapshot SHALL be absent, and offsets 0x0C/0x10 SHALL decode as unmapped (rsp_err=1).

Structure
REQ-039 A shared package sim_host_pkg SHALL hold the register-offset localparams, the FSM state enum and the STATUS bit positions.
REQ-040 The console FIFO SHALL be a separate sub-module, sim_host_fifo (parameters WIDTH and DEPTH; push/pop/full/empty/count), instantiated once.

Verification
REQ-041 Write CONSOLE with 0x41, then 0x42, with con_rdy=1 -> con_data=0x41 then 0x42 on consecutive con handshakes, and rsp_vld exactly one cycle after each request handshake.
REQ-042 con_rdy=0; write 8 bytes, then a 9th -> req_rdy=0 on the 9th while the FIFO is full, STATUS read after the 8th returns 0x1, CONSOLE read returns 8; raise con_rdy -> the 9th is accepted after the first pop.
REQ-043 Write TOHOST with 0x0000_0007, then 0x0000_0005 -> finish=1 and exit_code=3, both unchanged by the second write.
REQ-044 Read offset 0x14 -> rsp_err=1 and rsp_rdata=0; hold rsp_rdy=0 for 3 cycles -> response stable and req_rdy=0 throughout.
REQ-045 Reset released, then 100 cycles, then read CYCLE_LO then CYCLE_HI (with SIM_HOST_CYCLE_CNT_EN) -> CYCLE_LO value within 100..102, HI=0; without the macro -> rsp_err=1.
REQ-046 Deassert rst_n while rsp_vld=1 and 3 bytes are queued -> rsp_vld=0, con_vld=0 and finish=0 immediately, with no stale byte after release.

Source files
------------

// File: rtl/sim_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sim_host_pkg
// Description : Shared definitions for the simulation host block: register
//               byte offsets, control FSM state encoding and STATUS bit
//               positions.
// Revision    : 1.0 - initial release
// ============================================================================
package sim_host_pkg;

    // Register byte offsets
    localparam logic [7:0] OFS_CONSOLE  = 8'h00;
    localparam logic [7:0] OFS_STATUS   = 8'h04;
    localparam logic [7:0] OFS_TOHOST   = 8'h08;
    localparam logic [7:0] OFS_CYCLE_LO = 8'h0C;
    localparam logic [7:0] OFS_CYCLE_HI = 8'h10;

    // STATUS register bit positions
    localparam int STATUS_FULL_BIT   = 0;
    localparam int STATUS_EMPTY_BIT  = 1;
    localparam int STATUS_FINISH_BIT = 2;

    // Control FSM state encoding
    localparam logic [0:0] ST_IDLE_ENC = 1'b0;
    localparam logic [0:0] ST_RSP_ENC  = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RSP  = ST_RSP_ENC
    } state_e;

endpackage : sim_host_pkg
`default_nettype wire

// File: rtl/sim_host_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sim_host_fifo
// Description : Synchronous FIFO with wrap-bit pointers. A push while full is
//               accepted only when a pop happens in the same cycle. The head
//               output reads as zero while the FIFO is empty.
// Ports       : clk, rst_n        - clock, async active-low reset
//               push_i/push_data_i - write strobe and data
//               pop_i              - remove head (ignored while empty)
//               pop_data_o         - current head
//               full_o/empty_o     - status flags
//               count_o            - occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module sim_host_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // Same index with differing wrap bits means the writer is a lap ahead.
    assign w_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign w_do_pop  = pop_i && !w_empty;
    assign w_do_push = push_i && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_do_push) wptr_q <= wptr_q + 1'b1;
            if (w_do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage carries no reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

    assign pop_data_o = w_empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign full_o     = w_full;
    assign empty_o    = w_empty;
    assign count_o    = wptr_q - rptr_q;

endmodule : sim_host_fifo
`default_nettype wire

// File: rtl/sim_host.sv
`default_nettype none
// ============================================================================
// Module      : sim_host
// Description : Memory-mapped simulation host. Provides a console byte
//               stream, a sticky program-done flag with exit code and an
//               optional 64-bit cycle counter with coherent hi/lo reads.
//               One request outstanding; response one cycle after accept.
// Config      : define SIM_HOST_CYCLE_CNT_EN to include the cycle counter
//               and offsets 0x0C/0x10 (otherwise they decode as unmapped).
// Ports       : clk, rst_n                       - clock, async low reset
//               req_vld/req_rdy, req_addr, req_wr,
//               req_wdata, req_wstrb            - request channel
//               rsp_vld/rsp_rdy, rsp_rdata,
//               rsp_err                         - response channel
//               con_vld/con_rdy, con_data       - console byte stream
//               finish, exit_code               - program termination
// Revision    : 1.0 - initial release
// ============================================================================
module sim_host
    import sim_host_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int OFS_W      = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [31:0] req_addr,
    input  logic        req_wr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        con_vld,
    input  logic        con_rdy,
    output logic [7:0]  con_data,
    output logic        finish,
    output logic [30:0] exit_code
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int WW = OFS_W - 2;

    // Word indices of the register map at the decoded width
    localparam logic [WW-1:0] C_W_CONSOLE  = WW'(OFS_CONSOLE  >> 2);
    localparam logic [WW-1:0] C_W_STATUS   = WW'(OFS_STATUS   >> 2);
    localparam logic [WW-1:0] C_W_TOHOST   = WW'(OFS_TOHOST   >> 2);
`ifdef SIM_HOST_CYCLE_CNT_EN
    localparam logic [WW-1:0] C_W_CYCLE_LO = WW'(OFS_CYCLE_LO >> 2);
    localparam logic [WW-1:0] C_W_CYCLE_HI = WW'(OFS_CYCLE_HI >> 2);
`endif

    state_e        state_q;
    state_e        state_d;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;
    logic          finish_q;
    logic [30:0]   exit_code_q;

    logic [WW-1:0] w_word;
    logic          w_req_fire;
    logic          w_is_console;
    logic          w_is_tohost;
    logic          w_con_push;
    logic          w_tohost_set;
    logic [31:0]   w_rdata;
    logic          w_err;

    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW:0]   w_fifo_count;
    logic [7:0]    w_fifo_head;

`ifdef SIM_HOST_CYCLE_CNT_EN
    logic [63:0]   cycle_q;
    logic [31:0]   snap_q;
    logic          w_is_cyc_lo;
`endif

    // Address bits outside the decoded window and the upper strobes are
    // deliberately ignored.
    logic          w_unused;
    assign w_unused = ^{req_addr[31:OFS_W], req_addr[1:0], req_wstrb[3:1]};

    assign w_word = req_addr[OFS_W-1:2];

    // ------------------------------------------------------------------
    // Address decode and read-data mux (evaluated at accept time)
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata      = '0;
        w_err        = 1'b0;
        w_is_console = 1'b0;
        w_is_tohost  = 1'b0;
`ifdef SIM_HOST_CYCLE_CNT_EN
        w_is_cyc_lo  = 1'b0;
`endif
        if (w_word == C_W_CONSOLE) begin
            w_is_console = 1'b1;
            w_rdata      = 32'(w_fifo_count);
        end else if (w_word == C_W_STATUS) begin
            w_rdata[STATUS_FULL_BIT]   = w_fifo_full;
            w_rdata[STATUS_EMPTY_BIT]  = w_fifo_empty;
            w_rdata[STATUS_FINISH_BIT] = finish_q;
        end else if (w_word == C_W_TOHOST) begin
            w_is_tohost = 1'b1;
            w_rdata     = {exit_code_q, finish_q};
`ifdef SIM_HOST_CYCLE_CNT_EN
        end else if (w_word == C_W_CYCLE_LO) begin
            w_is_cyc_lo = 1'b1;
            w_rdata     = cycle_q[31:0];
        end else if (w_word == C_W_CYCLE_HI) begin
            w_rdata     = snap_q;
`endif
        end else begin
            w_err = 1'b1;
        end
        if (req_wr) w_rdata = '0;
    end

    // Back-pressure only for an effective console write into a full FIFO;
    // rst_n gating keeps req_rdy low for the whole reset interval.
    assign req_rdy = rst_n && (state_q == ST_IDLE) &&
                     !(req_vld && req_wr && req_wstrb[0] && w_is_console &&
                       w_fifo_full);

    assign w_req_fire   = req_vld && req_rdy;
    assign w_con_push   = w_req_fire && req_wr && req_wstrb[0] && w_is_console;
    // Only the first terminating write is latched.
    assign w_tohost_set = w_req_fire && req_wr && req_wstrb[0] && w_is_tohost &&
                          req_wdata[0] && !finish_q;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_req_fire) state_d = ST_RSP;
            ST_RSP:  if (rsp_rdy)    state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            finish_q    <= 1'b0;
            exit_code_q <= '0;
        end else begin
            state_q <= state_d;
            // Response registers only load on accept, so they stay stable
            // for as long as the response is stalled.
            if (w_req_fire) begin
                rsp_rdata_q <= w_rdata;
                rsp_err_q   <= w_err;
            end
            if (w_tohost_set) begin
                finish_q    <= 1'b1;
                exit_code_q <= req_wdata[31:1];
            end
        end
    end

`ifdef SIM_HOST_CYCLE_CNT_EN
    // ------------------------------------------------------------------
    // Free-running cycle counter; reading LO captures HI for a coherent pair
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            snap_q  <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (w_req_fire && !req_wr && w_is_cyc_lo) snap_q <= cycle_q[63:32];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Console FIFO
    // ------------------------------------------------------------------
    sim_host_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_con_push),
        .push_data_i (req_wdata[7:0]),
        .pop_i       (con_rdy),
        .pop_data_o  (w_fifo_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .count_o     (w_fifo_count)
    );

    assign rsp_vld   = (state_q == ST_RSP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign con_vld   = !w_fifo_empty;
    assign con_data  = w_fifo_head;
    assign finish    = finish_q;
    assign exit_code = exit_code_q;

endmodule : sim_host
`default_nettype wire
